// File: rtl/cdc_bus_scheduler_if.sv
// Request and transfer signals shared by the requesters and cdc_bus_scheduler.
// The scheduler uses the slave modport; the requester side uses master.
interface cdc_bus_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BUS     = 4
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     i_req;
  logic [NUM_REQ*BUS-1:0] i_data;
  logic [NUM_REQ-1:0]     o_grant;
  logic                   o_busy;
  logic [IdW-1:0]         o_src_id;
  logic [BUS-1:0]         o_async_bus;
  logic                   o_bus_enable;
  logic [15:0]            o_xfer_count;

  modport master (
    output i_req, i_data,
    input  o_grant, o_busy, o_src_id, o_async_bus, o_bus_enable, o_xfer_count
  );

  modport slave (
    input  i_req, i_data,
    output o_grant, o_busy, o_src_id, o_async_bus, o_bus_enable, o_xfer_count
  );
endinterface

// File: rtl/cdc_bus_scheduler.sv
// Round-robin scheduler sharing one data_sync crossing: enable high HOLD_CYCLES, low GAP_CYCLES.
// Optional transfer counter is built when CDC_SCHED_XFER_COUNT_EN is defined.
module cdc_bus_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BUS         = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input logic                i_clk,
  input logic                i_arst,
  cdc_bus_scheduler_if.slave bus_if
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned MaxCyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES);
  localparam logic [IdW:0]    NumReqW  = (IdW + 1)'(NUM_REQ);
  localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [IdW-1:0]     r_ptr;
  logic [IdW-1:0]     r_src_id;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic               r_bus_enable;
  logic [BUS-1:0]     r_async_bus;

  logic [BUS-1:0]     w_data_arr [NUM_REQ];
  logic [IdW:0]       w_sum;
  logic [IdW-1:0]     w_idx;
  logic [IdW-1:0]     w_winner;
  logic [IdW-1:0]     w_next_ptr;
  logic               w_found;
  logic               w_gap_done;
  logic               w_accept;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_data_arr[k] = bus_if.i_data[k*BUS +: BUS];
  end

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IdW + 1)'(i);
      if (w_sum >= NumReqW) w_sum = w_sum - NumReqW;
      w_idx = w_sum[IdW-1:0];
      if (!w_found && bus_if.i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_next_ptr = (w_winner == LastId) ? '0 : w_winner + 1'b1;
  assign w_gap_done = (r_state == StGap) && (r_cnt == GapLast);
  // The last GAP edge doubles as an IDLE decision so back-to-back period is HOLD+GAP.
  assign w_accept   = ((r_state == StIdle) || w_gap_done) && w_found;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_src_id     <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_bus_enable <= 1'b0;
      r_async_bus  <= '0;
    end else begin
      r_grant <= '0;
      if (w_accept) begin
        r_state      <= StHold;
        r_cnt        <= CntW'(1);
        r_ptr        <= w_next_ptr;
        r_src_id     <= w_winner;
        r_async_bus  <= w_data_arr[w_winner];
        r_grant      <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_winner;
        r_busy       <= 1'b1;
        r_bus_enable <= 1'b1;
      end else begin
        unique case (r_state)
          StHold: begin
            if (r_cnt == HoldLast) begin
              r_state      <= StGap;
              r_cnt        <= CntW'(1);
              r_bus_enable <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          StGap: begin
            if (w_gap_done) begin
              r_state <= StIdle;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_if.o_grant      = r_grant;
  assign bus_if.o_busy       = r_busy;
  assign bus_if.o_src_id     = r_src_id;
  assign bus_if.o_async_bus  = r_async_bus;
  assign bus_if.o_bus_enable = r_bus_enable;

`ifdef CDC_SCHED_XFER_COUNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_xfer_count <= '0;
    end else if (w_gap_done) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign bus_if.o_xfer_count = r_xfer_count;
`else
  assign bus_if.o_xfer_count = 16'd0;
`endif

endmodule
